// File: rtl/paddle_ctrl.sv
// Paddle position controller: synchronizes and debounces btnU/btnD, then steps a
// clamped paddle position once per press with auto-repeat while a button is held.
module paddle_ctrl #(
  parameter int POS_W        = 6,
  parameter int POS_MIN      = 0,
  parameter int POS_MAX      = 56,
  parameter int POS_INIT     = 32,
  parameter int DEB_COUNT    = 250000,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 1250000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_up_raw,
  input  logic             btn_dn_raw,
  input  logic             enable,
  input  logic             center,
  output logic [POS_W-1:0] paddle_pos,
  output logic             step,
  output logic             at_top,
  output logic             at_bottom
);

  localparam int DEB_W   = $clog2(DEB_COUNT + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]            raw_btn;
  logic [1:0]            sync_a;
  logic [1:0]            sync_b;
  logic [1:0]            deb_lvl;
  logic [1:0][DEB_W-1:0] deb_cnt;

  state_t                state, state_nxt;
  logic [RPT_W-1:0]      rpt_cnt, rpt_nxt;
  logic                  dir_dn, dir_nxt;
  logic                  step_req;
  logic                  one_hot;
  logic                  press_dn;

  logic [POS_W-1:0]      pos_nxt;
  logic                  step_nxt;

  assign raw_btn  = {btn_dn_raw, btn_up_raw};
  assign one_hot  = deb_lvl[0] ^ deb_lvl[1];
  assign press_dn = deb_lvl[1];

  // A level change is accepted only after DEB_COUNT consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a  <= '0;
      sync_b  <= '0;
      deb_lvl <= '0;
      deb_cnt <= '0;
    end else begin
      sync_a <= raw_btn;
      sync_b <= sync_a;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_COUNT - 1)) begin
          deb_lvl[i] <= ~deb_lvl[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rpt_cnt <= '0;
      dir_dn  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_nxt;
      dir_dn  <= dir_nxt;
    end
  end

  // A change of held direction drops back to IDLE so the new press restarts the delay.
  always_comb begin
    state_nxt = state;
    rpt_nxt   = rpt_cnt;
    dir_nxt   = dir_dn;
    step_req  = 1'b0;
    case (state)
      IDLE: begin
        if (one_hot && enable) begin
          step_req  = 1'b1;
          rpt_nxt   = RPT_W'(REPEAT_DELAY - 1);
          dir_nxt   = press_dn;
          state_nxt = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!one_hot || !enable || (press_dn != dir_dn)) begin
          state_nxt = IDLE;
        end else if (rpt_cnt == '0) begin
          step_req  = 1'b1;
          rpt_nxt   = RPT_W'(REPEAT_RATE - 1);
          state_nxt = REPEAT;
        end else begin
          rpt_nxt = rpt_cnt - RPT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Center wins over a step; steps that would leave the field are dropped silently.
  always_comb begin
    pos_nxt  = paddle_pos;
    step_nxt = 1'b0;
    if (center) begin
      pos_nxt  = POS_W'(POS_INIT);
      step_nxt = (paddle_pos != POS_W'(POS_INIT));
    end else if (step_req) begin
      if (dir_nxt && (paddle_pos != POS_W'(POS_MAX))) begin
        pos_nxt  = paddle_pos + POS_W'(1);
        step_nxt = 1'b1;
      end else if (!dir_nxt && (paddle_pos != POS_W'(POS_MIN))) begin
        pos_nxt  = paddle_pos - POS_W'(1);
        step_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      paddle_pos <= POS_W'(POS_INIT);
      step       <= 1'b0;
    end else begin
      paddle_pos <= pos_nxt;
      step       <= step_nxt;
    end
  end

  assign at_top    = (paddle_pos == POS_W'(POS_MIN));
  assign at_bottom = (paddle_pos == POS_W'(POS_MAX));

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed button scenarios plus random button traffic,
// compared every cycle against a press-duration model of the paddle.
module tb_paddle_ctrl;

  localparam int DEB   = 4;
  localparam int DLY   = 10;
  localparam int RATE  = 3;
  localparam int PMIN  = 0;
  localparam int PMAX  = 56;
  localparam int PINIT = 32;

  logic       clk        = 1'b0;
  logic       reset_n    = 1'b0;
  logic       btn_up_raw = 1'b0;
  logic       btn_dn_raw = 1'b0;
  logic       enable     = 1'b1;
  logic       center     = 1'b0;
  logic [5:0] paddle_pos;
  logic       step;
  logic       at_top;
  logic       at_bottom;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  paddle_ctrl #(
    .POS_W(6), .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_INIT(PINIT),
    .DEB_COUNT(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_up_raw(btn_up_raw), .btn_dn_raw(btn_dn_raw),
    .enable(enable), .center(center), .paddle_pos(paddle_pos), .step(step),
    .at_top(at_top), .at_bottom(at_bottom)
  );

  // Model state: accepted button levels come from a sliding window of synced samples,
  // motion from how long the same single button has been continuously accepted.
  int           m_pos = PINIT;
  bit           m_step;
  bit [1:0]     m_s1, m_s2, m_deb;
  bit [DEB-1:0] m_win [2];
  bit           m_active, m_dir, m_want;
  int           m_held;
  int           m_cand;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_pos    = PINIT;
      m_step   = 1'b0;
      m_s1     = '0;
      m_s2     = '0;
      m_deb    = '0;
      m_win[0] = '0;
      m_win[1] = '0;
      m_active = 1'b0;
      m_held   = 0;
    end else begin
      m_want = 1'b0;
      if (!((m_deb[0] ^ m_deb[1]) && enable)) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_held   = 0;
        m_dir    = m_deb[1];
        m_want   = 1'b1;
      end else if (m_deb[1] != m_dir) begin
        m_active = 1'b0;
      end else begin
        m_held = m_held + 1;
        if (m_held == DLY || (m_held > DLY && (m_held - DLY) % RATE == 0)) m_want = 1'b1;
      end
      m_step = 1'b0;
      if (center) begin
        m_step = (m_pos != PINIT);
        m_pos  = PINIT;
      end else if (m_want) begin
        m_cand = m_dir ? m_pos + 1 : m_pos - 1;
        if (m_cand >= PMIN && m_cand <= PMAX) begin
          m_pos  = m_cand;
          m_step = 1'b1;
        end
      end
      for (int b = 0; b < 2; b++) begin
        m_win[b] = {m_win[b][DEB-2:0], m_s2[b]};
        if (m_win[b] == {DEB{~m_deb[b]}}) m_deb[b] = ~m_deb[b];
      end
      m_s2 = m_s1;
      m_s1 = {btn_dn_raw, btn_up_raw};
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit up, input bit dn, input bit en, input bit cen,
                               input int cycles);
    btn_up_raw = up;
    btn_dn_raw = dn;
    enable     = en;
    center     = cen;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial forever begin
    @(negedge clk);
    checkOutput("model_pos", int'(paddle_pos), m_pos);
    checkOutput("model_step", int'(step), int'(m_step));
    checkOutput("model_at_top", int'(at_top), int'(m_pos == PMIN));
    checkOutput("model_at_bottom", int'(at_bottom), int'(m_pos == PMAX));
  end

  initial begin
    bit r_up, r_dn, r_en;

    reset_n = 1'b0;
    applyStimulus(0, 0, 1, 0, 3);
    checkOutput("t1_pos", int'(paddle_pos), 32);
    checkOutput("t1_step", int'(step), 0);
    checkOutput("t1_at_top", int'(at_top), 0);
    checkOutput("t1_at_bottom", int'(at_bottom), 0);
    reset_n = 1'b1;

    repeat (3) begin
      applyStimulus(0, 1, 1, 0, 2);
      applyStimulus(0, 0, 1, 0, 2);
    end
    applyStimulus(0, 0, 1, 0, 4);
    checkOutput("t2_glitch_ignored", int'(paddle_pos), 32);
    applyStimulus(0, 1, 1, 0, 6);
    checkOutput("t2_before_latency", int'(paddle_pos), 32);
    applyStimulus(0, 1, 1, 0, 1);
    checkOutput("t2_first_step_pos", int'(paddle_pos), 33);
    checkOutput("t2_first_step_pulse", int'(step), 1);
    applyStimulus(0, 0, 1, 0, 10);
    checkOutput("t2_release", int'(paddle_pos), 33);

    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("t3_center", int'(paddle_pos), 32);
    applyStimulus(1, 0, 1, 0, 36);
    checkOutput("t3_repeat_pos", int'(paddle_pos), 24);

    applyStimulus(1, 0, 1, 0, 150);
    checkOutput("t4_top_pos", int'(paddle_pos), 0);
    checkOutput("t4_top_flag", int'(at_top), 1);
    repeat (10) begin
      applyStimulus(1, 0, 1, 0, 1);
      checkOutput("t4_top_no_step", int'(step), 0);
    end
    applyStimulus(0, 0, 1, 0, 8);
    applyStimulus(0, 1, 1, 0, 250);
    checkOutput("t4_bottom_pos", int'(paddle_pos), 56);
    checkOutput("t4_bottom_flag", int'(at_bottom), 1);
    applyStimulus(0, 0, 1, 0, 8);

    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(1, 1, 1, 0, 30);
    checkOutput("t5_both_held", int'(paddle_pos), 32);
    applyStimulus(0, 1, 1, 0, 6);
    checkOutput("t5_release_wait", int'(paddle_pos), 32);
    applyStimulus(0, 1, 1, 0, 1);
    checkOutput("t5_release_step", int'(paddle_pos), 33);
    applyStimulus(0, 1, 1, 0, 12);
    checkOutput("t5_in_repeat", int'(paddle_pos), 34);
    applyStimulus(0, 1, 0, 0, 20);
    checkOutput("t5_frozen", int'(paddle_pos), 34);
    applyStimulus(0, 1, 1, 0, 1);
    checkOutput("t5_reenable_step", int'(paddle_pos), 35);

    applyStimulus(0, 1, 1, 0, 12);
    checkOutput("t6_before_center", int'(paddle_pos), 36);
    applyStimulus(0, 1, 1, 1, 1);
    checkOutput("t6_center", int'(paddle_pos), 32);
    applyStimulus(0, 1, 1, 0, 5);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_async_reset_pos", int'(paddle_pos), 32);
    checkOutput("t6_async_reset_step", int'(step), 0);
    applyStimulus(0, 1, 1, 0, 2);
    reset_n = 1'b1;
    applyStimulus(0, 1, 1, 0, 6);
    checkOutput("t6_post_reset_wait", int'(paddle_pos), 32);
    applyStimulus(0, 1, 1, 0, 1);
    checkOutput("t6_post_reset_step", int'(paddle_pos), 33);
    applyStimulus(0, 0, 1, 0, 10);

    r_up = 1'b0;
    r_dn = 1'b0;
    r_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) r_up = ~r_up;
      if ($urandom_range(0, 15) == 0) r_dn = ~r_dn;
      if ($urandom_range(0, 39) == 0) r_en = ~r_en;
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        applyStimulus(r_up, r_dn, r_en, 0, 1);
        reset_n = 1'b1;
      end
      applyStimulus(r_up, r_dn, r_en, ($urandom_range(0, 119) == 0), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
